// File: rtl/neuron8_layer_seq.sv
// Layer sequencer: latches one input vector, walks the weight ROM issuing one neuron
// per cycle to a shared 8-input datapath, and streams the returned results with their index.
module neuron8_layer_seq #(
  parameter int NUM_NEURONS = 8,
  parameter int ADDR_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               use_relu,
  input  logic [63:0]        x_in,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  wrom_addr,
  input  logic [71:0]        wrom_data,
  output logic [63:0]        nrn_x,
  output logic [63:0]        nrn_w,
  output logic [7:0]         nrn_bias,
  output logic               nrn_relu,
  output logic               nrn_valid,
  input  logic signed [15:0] nrn_out,
  input  logic               nrn_valid_out,
  output logic               res_valid,
  output logic [ADDR_W-1:0]  res_idx,
  output logic signed [15:0] res_data
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [CW-1:0]     CNT_N     = CW'(NUM_NEURONS);
  localparam logic [CW-1:0]     CNT_LAST  = CW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state;
  logic            fetch_vld_p0;
  logic [CW-1:0]   res_cnt;

  // ROM word feeds the datapath directly; it lines up with nrn_valid one cycle after the address
  assign nrn_w    = wrom_data[63:0];
  assign nrn_bias = wrom_data[71:64];

  // p0: address issue; p1: ROM data valid at the datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      wrom_addr    <= '0;
      fetch_vld_p0 <= 1'b0;
      nrn_valid    <= 1'b0;
      nrn_x        <= '0;
      nrn_relu     <= 1'b0;
    end else begin
      nrn_valid <= fetch_vld_p0;
      case (state)
        IDLE: begin
          if (start) begin
            nrn_x        <= x_in;
            nrn_relu     <= use_relu;
            wrom_addr    <= '0;
            fetch_vld_p0 <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (wrom_addr == LAST_ADDR) begin
            fetch_vld_p0 <= 1'b0;
            state        <= DRAIN;
          end else begin
            wrom_addr <= wrom_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (res_cnt == CNT_N) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result stage: capture datapath output; counter saturates at NUM_NEURONS so strays are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
      res_cnt   <= '0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE && start) begin
        res_cnt <= '0;
      end else if (nrn_valid_out && busy && (res_cnt < CNT_N)) begin
        res_valid <= 1'b1;
        res_data  <= nrn_out;
        res_idx   <= res_cnt[ADDR_W-1:0];
        res_cnt   <= res_cnt + 1'b1;
        done      <= (res_cnt == CNT_LAST);
      end
    end
  end

endmodule

// File: tb/tb_neuron8_layer_seq.sv
// Bench for neuron8_layer_seq: ROM and 2-cycle neuron datapath models around the DUT,
// a pass-timeline reference model checked every cycle, and literal result checks.
module tb_neuron8_layer_seq;
  localparam int N  = 8;
  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        use_relu = 1'b0;
  logic [63:0] x_in = '0;
  logic        busy, done, nrn_relu, nrn_valid, res_valid;
  logic [AW-1:0] wrom_addr, res_idx;
  logic [71:0] wrom_data;
  logic [63:0] nrn_x, nrn_w;
  logic [7:0]  nrn_bias;
  logic [15:0] nrn_out, res_data;
  logic        nrn_valid_out;
  logic        stray = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int ndone = 0;
  logic [15:0] cap [0:N-1];
  logic [71:0] rom [0:N-1];

  always #5 clk = ~clk;

  neuron8_layer_seq #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .use_relu(use_relu), .x_in(x_in),
    .busy(busy), .done(done), .wrom_addr(wrom_addr), .wrom_data(wrom_data),
    .nrn_x(nrn_x), .nrn_w(nrn_w), .nrn_bias(nrn_bias), .nrn_relu(nrn_relu),
    .nrn_valid(nrn_valid), .nrn_out(nrn_out), .nrn_valid_out(nrn_valid_out),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
  );

  function automatic logic [15:0] neuron(input logic [63:0] x, input logic [71:0] wd,
                                         input logic relu);
    int acc;
    logic signed [7:0] a, b;
    b = wd[71:64];
    acc = int'(b);
    for (int i = 0; i < 8; i++) begin
      a = x[8*i +: 8];
      b = wd[8*i +: 8];
      acc += int'(a) * int'(b);
    end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    return 16'(acc);
  endfunction

  // Synchronous ROM and the 2-stage datapath sitting around the sequencer
  logic        dp_v1 = 1'b0, dp_v2 = 1'b0;
  logic [15:0] dp_d1, dp_d2;
  always @(posedge clk) wrom_data <= rom[wrom_addr];
  always @(posedge clk) begin
    if (reset) begin
      dp_v1 <= 1'b0;
      dp_v2 <= 1'b0;
    end else begin
      dp_v1 <= nrn_valid;
      dp_d1 <= neuron(nrn_x, {nrn_bias, nrn_w}, nrn_relu);
      dp_v2 <= dp_v1;
      dp_d2 <= dp_d1;
    end
  end
  assign nrn_out       = dp_d2;
  assign nrn_valid_out = dp_v2 | stray;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (res_valid === 1'b1) cap[res_idx] = res_data;
    if (done === 1'b1) ndone++;
  end

  // Reference: outputs as a function of cycles elapsed since the accepted start
  initial begin
    int cyc, s, rel;
    bit model_ok, eb, env, erv, ed;
    logic [AW-1:0] m_addr, m_idx;
    logic [63:0]   m_x;
    logic          m_relu;
    logic [15:0]   m_data;
    logic [15:0]   exp_res [0:N-1];
    cyc = 0; s = -1; model_ok = 0;
    m_addr = '0; m_idx = '0; m_x = '0; m_relu = 1'b0; m_data = '0;
    forever begin
      @(negedge clk);
      rel = (s >= 0) ? cyc - s : -1;
      eb  = (rel >= 1) && (rel <= N + 4);
      env = (rel >= 2) && (rel <= N + 1);
      erv = (rel >= 5) && (rel <= N + 4);
      ed  = (rel == N + 4);
      if (model_ok) begin
        if (rel >= 1 && rel <= N) m_addr = AW'(rel - 1);
        if (erv) begin
          m_idx  = AW'(rel - 5);
          m_data = exp_res[rel - 5];
        end
        chk("busy", 72'(busy), 72'(eb));
        chk("done", 72'(done), 72'(ed));
        chk("nrn_valid", 72'(nrn_valid), 72'(env));
        chk("res_valid", 72'(res_valid), 72'(erv));
        chk("wrom_addr", 72'(wrom_addr), 72'(m_addr));
        chk("res_idx", 72'(res_idx), 72'(m_idx));
        chk("res_data", 72'(res_data), 72'(m_data));
        chk("nrn_x", 72'(nrn_x), 72'(m_x));
        chk("nrn_relu", 72'(nrn_relu), 72'(m_relu));
        if (env) begin
          chk("nrn_w", 72'(nrn_w), 72'(rom[rel - 2][63:0]));
          chk("nrn_bias", 72'(nrn_bias), 72'(rom[rel - 2][71:64]));
        end
      end
      if (reset) begin
        model_ok = 1;
        s = -1;
        m_addr = '0; m_idx = '0; m_x = '0; m_relu = 1'b0; m_data = '0;
      end else if (model_ok && start && !eb) begin
        s = cyc;
        m_x = x_in;
        m_relu = use_relu;
        for (int k = 0; k < N; k++) exp_res[k] = neuron(x_in, rom[k], use_relu);
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [63:0] x, input logic relu, input int mid_start,
                          input int rst_at, input bit wiggle, input bit stray_end);
    for (int rel = 0; rel <= N + 4; rel++) begin
      start = (rel == 0) || (rel == mid_start);
      if (rel == 0) begin
        x_in = x;
        use_relu = relu;
      end else if (wiggle || rel == mid_start) begin
        x_in = {$urandom(), $urandom()};
        use_relu = 1'($urandom_range(0, 1));
      end
      stray = stray_end && (rel == N + 4);
      reset = (rel == rst_at);
      tick();
      if (rel == rst_at) begin
        reset = 1'b0;
        break;
      end
    end
    start = 1'b0;
    stray = 1'b0;
  endtask

  task automatic rom_uniform(input logic [7:0] w, input logic [7:0] b);
    for (int k = 0; k < N; k++) rom[k] = {b, {8{w}}};
  endtask

  task automatic rom_basic();
    for (int k = 0; k < N; k++) rom[k] = {8'h00, {8{8'(k)}}};
  endtask

  task automatic rom_random();
    for (int k = 0; k < N; k++) rom[k] = {8'($urandom()), $urandom(), $urandom()};
  endtask

  initial begin
    int n0;
    rom_basic();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    tick();

    n0 = ndone;
    run_pass({8{8'h01}}, 1'b0, 3, -1, 0, 0);
    chk("done_count_basic", 72'(ndone), 72'(n0 + 1));
    for (int k = 0; k < N; k++) chk("basic_data", 72'(cap[k]), 72'(16'(8 * k)));
    run_pass({8{8'h02}}, 1'b0, -1, -1, 0, 1);
    chk("done_count_back2back", 72'(ndone), 72'(n0 + 2));
    for (int k = 0; k < N; k++) chk("back2back_data", 72'(cap[k]), 72'(16'(16 * k)));

    rom_uniform(8'hFF, 8'h00);
    run_pass({8{8'd10}}, 1'b1, -1, -1, 0, 0);
    for (int k = 0; k < N; k++) chk("relu_on", 72'(cap[k]), 72'(16'h0000));
    run_pass({8{8'd10}}, 1'b0, -1, -1, 0, 0);
    for (int k = 0; k < N; k++) chk("relu_off", 72'(cap[k]), 72'(16'hFFB0));

    rom_uniform(8'h80, 8'h7F);
    run_pass({8{8'h80}}, 1'b0, -1, -1, 0, 0);
    for (int k = 0; k < N; k++) chk("sat_pos", 72'(cap[k]), 72'(16'h7FFF));
    rom_uniform(8'h80, 8'h00);
    run_pass({8{8'h7F}}, 1'b0, -1, -1, 0, 0);
    for (int k = 0; k < N; k++) chk("sat_neg", 72'(cap[k]), 72'(16'h8000));

    rom_random();
    n0 = ndone;
    run_pass({$urandom(), $urandom()}, 1'b0, -1, 7, 0, 0);
    tick();
    chk("done_after_reset", 72'(ndone), 72'(n0));
    for (int k = 0; k < N; k++) cap[k] = 16'hDEAD;
    rom_basic();
    run_pass({8{8'h01}}, 1'b0, -1, -1, 0, 0);
    chk("done_count_restart", 72'(ndone), 72'(n0 + 1));
    for (int k = 0; k < N; k++) chk("restart_data", 72'(cap[k]), 72'(16'(8 * k)));

    rom_random();
    run_pass({$urandom(), $urandom()}, 1'b1, -1, -1, 1, 0);

    for (int p = 0; p < 8; p++) begin
      rom_random();
      run_pass({$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N + 4)) : -1,
               -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/neuron8_layer_seq.md
Name: neuron8_layer_seq

Overview:
Sequencer that evaluates one fully-connected layer of NUM_NEURONS neurons on a single shared 8-input neuron datapath.
- On start, latches an 8-element input vector.
- Fetches each neuron's weights and bias from a synchronous weight ROM and issues one neuron per cycle to the datapath.
- Collects the datapath results and streams them out with the neuron index.
- Sits between the layer input buffer, the weight ROM and the neuron datapath instance.

Parameters:
- NUM_NEURONS, 8, neurons per layer (1..2^ADDR_W).
- ADDR_W, 3, width of the ROM address and result index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a layer pass; sampled only when idle
- use_relu  in  1  ReLU enable; latched with start
- x_in  in  64  input vector; x0 in [7:0] … x7 in [63:56]; signed 8-bit each
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse with the last result
- wrom_addr  out  ADDR_W  weight ROM address
- wrom_data  in  72  ROM word {bias[71:64], w7 … w0}; w0 in [7:0]; read latency 1 cycle
- nrn_x  out  64  latched input vector to the datapath
- nrn_w  out  64  weights to the datapath (wrom_data[63:0])
- nrn_bias  out  8  bias to the datapath (wrom_data[71:64])
- nrn_relu  out  1  latched use_relu
- nrn_valid  out  1  datapath issue strobe
- nrn_out  in  16  datapath result, signed, saturated
- nrn_valid_out  in  1  datapath result strobe
- res_valid  out  1  result strobe
- res_idx  out  ADDR_W  neuron index of the result
- res_data  out  16  signed result

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0. The neuron datapath shares clk and reset.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE.
- States:
  - IDLE: on start=1, latch x_in → nrn_x and use_relu → nrn_relu; clear the issue and result counters; go to ISSUE.
  - ISSUE: in cycle 1+k, wrom_addr=k with an internal fetch-valid flag. The issue counter increments every cycle. After address NUM_NEURONS-1, go to DRAIN.
  - DRAIN: wait until NUM_NEURONS results have been received, then return to IDLE.
- Issue timing:
  - nrn_valid is the fetch-valid flag delayed by 1 cycle, so it is high in cycles 2 .. NUM_NEURONS+1, aligned with the ROM data.
  - nrn_w and nrn_bias pass wrom_data through combinationally. Their value is don't-care while nrn_valid=0.
- wrom_addr holds its last value outside ISSUE.
- Datapath latency is 2 cycles: nrn_valid_out rises in cycle 4+k.
- Result path: registered. On nrn_valid_out while busy:
  - res_valid=1 next cycle (cycle 5+k);
  - res_data = nrn_out;
  - res_idx = result counter; the counter then increments.
- res_valid is 0 in all other cycles. res_data and res_idx hold their last value.
- done pulses with the result for index NUM_NEURONS-1 (cycle NUM_NEURONS+4).
- busy is high in cycles 1 .. NUM_NEURONS+4 and low from cycle NUM_NEURONS+5.
- Boundary conditions:
  - start while busy: ignored; nrn_x and nrn_relu are unchanged.
  - start in the cycle busy falls: accepted.
  - nrn_valid_out while idle, or after NUM_NEURONS results: ignored; no res_valid, and the counter does not wrap.
  - x_in and use_relu changes after cycle 0: no effect on the current pass.
  - NUM_NEURONS=1: nrn_valid high in cycle 2 only; done in cycle 5.
  - reset mid-pass: next cycle all outputs are 0 and the FSM is in IDLE; no done pulse; the next start restarts at index 0.
- No backpressure: downstream must accept one result per cycle.

Test Plan:
- Basic pass, NUM_NEURONS=8: x all 1, ROM word k has all w=k and bias 0 → res_data=8k, res_idx=k in cycle 5+k; done in cycle 12; busy low in cycle 13.
- ReLU: x all 10, all w=-1, bias 0:
  - use_relu=1 → every res_data=0;
  - use_relu=0 → every res_data=-80 (0xFFB0).
- Saturation: x all -128, w all -128, bias 127 → res_data=32767. Also x all 127, w all -128 → res_data=-32768.
- Start handling: start pulsed in cycle 3 with a different x_in → ignored, results unchanged. Start in cycle 13 → second pass with correct results in cycles 18..25.
- Reset at cycle 7 → outputs 0 in cycle 8, no done pulse. A fresh start yields res_idx 0..7 with correct data.
- Input hold: x_in changed every cycle after cycle 0 → results match the x_in sampled in cycle 0.
